// File: rtl/exc_ctrl.sv
// exc_ctrl: MEM-stage exception/interrupt commit controller.
// Each cycle it picks at most one event (interrupt, exception or eret) by MIPS
// priority. It drives the CP0 exc_* write port and the pipeline flush, and it
// holds a fetch redirect until the fetch stage accepts it.
//
// Redirect handshake: redirect_valid is high for every cycle spent in REDIR.
// redirect_pc stays stable while redirect_valid is high. The redirect is
// consumed on the first rising edge where redirect_valid && redirect_ready,
// and the controller returns to IDLE at that edge. redirect_valid does not
// depend on redirect_ready.
module exc_ctrl #(
    parameter logic [31:0] VEC_BEV1 = 32'hBFC00380,
    parameter logic [31:0] VEC_BEV0 = 32'h80000180
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m_valid,
    input  logic [31:0] m_pc,
    input  logic        m_bd,
    input  logic        m_exc_if_adel,
    input  logic        m_exc_ri,
    input  logic        m_exc_ov,
    input  logic        m_exc_sys,
    input  logic        m_exc_bp,
    input  logic        m_exc_adel,
    input  logic        m_exc_ades,
    input  logic [31:0] m_dvaddr,
    input  logic        m_eret,
    input  logic        int_pending,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_epc,
    output logic        exc_valid,
    output logic [4:0]  exc_excode,
    output logic        exc_bd,
    output logic [31:0] exc_epc,
    output logic [31:0] exc_badvaddr,
    output logic        exc_eret,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        dbg_state
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_REDIR = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        any_exc;
    logic        ev_take;
    logic        ev_is_eret;
    logic [4:0]  sel_excode;
    logic [31:0] sel_badvaddr;
    logic [31:0] redir_target;
    logic [31:0] redirect_pc_q;

    // Event detection. An eret that also carries a fault or an interrupt is
    // handled as that exception. Gating with resetn keeps every output quiet
    // while reset is held.
    always_comb begin
        any_exc    = m_exc_if_adel | m_exc_ri | m_exc_ov | m_exc_sys |
                     m_exc_bp | m_exc_adel | m_exc_ades;
        ev_take    = resetn && (state_q == S_IDLE) && m_valid &&
                     (any_exc || int_pending || m_eret);
        ev_is_eret = m_eret && !any_exc && !int_pending;
    end

    // Priority encoder: interrupt first, then the fetch-side faults, then the
    // execute-side faults, then the data-side faults.
    always_comb begin
        sel_excode   = 5'h00;
        sel_badvaddr = 32'h0;
        if (int_pending) begin
            sel_excode = 5'h00;
        end else if (m_exc_if_adel) begin
            sel_excode   = 5'h04;
            sel_badvaddr = m_pc;
        end else if (m_exc_ri) begin
            sel_excode = 5'h0A;
        end else if (m_exc_ov) begin
            sel_excode = 5'h0C;
        end else if (m_exc_sys) begin
            sel_excode = 5'h08;
        end else if (m_exc_bp) begin
            sel_excode = 5'h09;
        end else if (m_exc_adel) begin
            sel_excode   = 5'h04;
            sel_badvaddr = m_dvaddr;
        end else if (m_exc_ades) begin
            sel_excode   = 5'h05;
            sel_badvaddr = m_dvaddr;
        end
    end

    // Fetch target. An eret returns to EPC. An exception goes to the vector
    // selected by Status.BEV.
    always_comb begin
        if (ev_is_eret) begin
            redir_target = cp0_epc;
        end else if (cp0_status[22]) begin
            redir_target = VEC_BEV1;
        end else begin
            redir_target = VEC_BEV0;
        end
    end

    // State register. Reset drops any pending redirect.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: enter REDIR on an event, leave it on handshake.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (ev_take) state_d = S_REDIR;
            S_REDIR: if (redirect_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Redirect target register. It loads at the event edge and holds through REDIR.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            redirect_pc_q <= 32'h0;
        end else if (ev_take) begin
            redirect_pc_q <= redir_target;
        end
    end

    // Output logic. The CP0 write port is combinational in the event cycle.
    // The flush covers the event cycle and every cycle spent in REDIR.
    always_comb begin
        exc_valid      = 1'b0;
        exc_excode     = 5'h00;
        exc_bd         = 1'b0;
        exc_epc        = 32'h0;
        exc_badvaddr   = 32'h0;
        exc_eret       = 1'b0;
        redirect_valid = resetn && (state_q == S_REDIR);
        flush          = ev_take || redirect_valid;
        redirect_pc    = redirect_pc_q;
        dbg_state      = state_q;
        if (ev_take) begin
            exc_valid = 1'b1;
            if (ev_is_eret) begin
                exc_eret = 1'b1;
            end else begin
                exc_excode   = sel_excode;
                exc_bd       = m_bd;
                exc_epc      = m_bd ? (m_pc - 32'd4) : m_pc;
                exc_badvaddr = sel_badvaddr;
            end
        end
    end

endmodule
